// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Producer-side hazard unit for the 5-stage MIPS pipeline. It keeps a shadow
//   of {valid, regwrite, memread, dst} for the instructions in EX, MEM and WB.
//   It detects load-use hazards that forwarding cannot cover and drives the
//   stall, bubble, flush and hold controls. It also keeps stall and bubble
//   performance counters.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-low reset
//   id_*                          decoded fields of the instruction in ID
//   branch_taken_i                branch/jump resolved taken in ID
//   mem_busy_i                    data memory not ready, freeze pipeline
//   pc_write_o, if_id_write_o     front-end load enables
//   if_id_flush_o                 clear IF_ID to NOP
//   id_ex_bubble_o                load NOP control into ID_EX
//   pipe_hold_o                   hold ID_EX, EX_MEM, MEM_WB
//   state_o                       00 RUN, 01 LU_STALL, 10 MEM_HOLD
//   stall_cnt_o, bubble_cnt_o     wrapping performance counters
//
// state    | meaning
// RUN      | last cycle advanced normally (or a branch flushed IF_ID)
// LU_STALL | last cycle inserted a load-use bubble
// MEM_HOLD | last cycle froze the pipe for a busy data memory

module hazard_stall_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [REG_W-1:0] id_dst_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_hold_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_HOLD = 2'b10
    } state_t;

    typedef struct packed {
        logic             v;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dst;
    } shadow_t;

    state_t  state, state_nxt;
    shadow_t ex_q, mem_q, wb_q;
    shadow_t id_entry, ex_in;
    logic    lu;
    logic    advance;

    // Invalid slots are stored all-zero so a stale dst can never match.
    always_comb begin
        id_entry = '0;
        if (id_valid_i) begin
            id_entry.v        = 1'b1;
            id_entry.regwrite = id_regwrite_i;
            id_entry.memread  = id_memread_i;
            id_entry.dst      = id_dst_i;
        end
    end

    assign lu = id_valid_i & ex_q.v & ex_q.memread & ex_q.regwrite
              & (ex_q.dst != '0)
              & ((ex_q.dst == id_rs_i) | (id_uses_rt_i & (ex_q.dst == id_rt_i)));

    always_comb begin
        state_nxt      = RUN;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_hold_o    = 1'b0;
        advance        = 1'b1;
        ex_in          = id_entry;
        if (!rst_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            advance        = 1'b0;
        end else if (mem_busy_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            pipe_hold_o   = 1'b1;
            advance       = 1'b0;
            state_nxt     = MEM_HOLD;
        end else if (lu) begin
            // Branch resolution is deferred: ID sees the same instruction again.
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            ex_in          = '0;
            state_nxt      = LU_STALL;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= RUN;
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (advance) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_in;
            end
            if (!pc_write_o)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (id_ex_bubble_o)
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

    // Empty slots must stay fully cleared as they move down the shadow pipe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            assert ((ex_q.v  || ex_q  == '0) &&
                    (mem_q.v || mem_q == '0) &&
                    (wb_q.v  || wb_q  == '0));
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             id_valid_i;
    logic [REG_W-1:0] id_rs_i, id_rt_i, id_dst_i;
    logic             id_uses_rt_i, id_regwrite_i, id_memread_i;
    logic             branch_taken_i, mem_busy_i;
    logic             pc_write_o, if_id_write_o, if_id_flush_o;
    logic             id_ex_bubble_o, pipe_hold_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o;

    int passed = 0;
    int total  = 0;

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_uses_rt_i   (id_uses_rt_i),
        .id_dst_i       (id_dst_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .branch_taken_i (branch_taken_i),
        .mem_busy_i     (mem_busy_i),
        .pc_write_o     (pc_write_o),
        .if_id_write_o  (if_id_write_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .pipe_hold_o    (pipe_hold_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .bubble_cnt_o   (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic [4:0] dst,
                          input logic rw, input logic mr);
        id_valid_i    = v;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_uses_rt_i  = ur;
        id_dst_i      = dst;
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    // lw $dst, 0($29)
    task automatic set_lw(input logic [4:0] dst);
        set_id(1'b1, 5'd29, dst, 1'b0, dst, 1'b1, 1'b1);
    endtask

    // add $9, $rs, $rt
    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, rs, rt, 1'b1, 5'd9, 1'b1, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0;
        mem_busy_i = 1'b0;
        branch_taken_i = 1'b0;
        set_lw(5'd8);
        tick();
        tick();
        chk("rst_pc_write", pc_write_o, 0);
        chk("rst_if_id_write", if_id_write_o, 0);
        chk("rst_bubble", id_ex_bubble_o, 1);
        chk("rst_flush", if_id_flush_o, 0);
        chk("rst_hold", pipe_hold_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_bubble_cnt", bubble_cnt_o, 0);

        rst_i = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 chk("release_pc_write", pc_write_o, 1);
        tick();

        // lw $8 ; add $9,$8,$1
        set_lw(5'd8);
        #1 chk("lw_pc_write", pc_write_o, 1);
        tick();
        set_add(5'd8, 5'd1);
        #1 chk("lu_pc_write", pc_write_o, 0);
        chk("lu_bubble", id_ex_bubble_o, 1);
        chk("lu_if_id_write", if_id_write_o, 0);
        chk("lu_flush", if_id_flush_o, 0);
        tick();
        chk("lu_state", state_o, 1);
        #1 chk("lu_resume_pc", pc_write_o, 1);
        chk("lu_resume_bubble", id_ex_bubble_o, 0);
        tick();
        chk("lu_state_run", state_o, 0);
        chk("lu_stall_cnt", stall_cnt_o, 1);
        chk("lu_bubble_cnt", bubble_cnt_o, 1);

        // No false stalls
        set_lw(5'd8);
        tick();
        set_add(5'd1, 5'd2);
        #1 chk("nodep_pc_write", pc_write_o, 1);
        tick();
        set_lw(5'd0);
        tick();
        set_add(5'd0, 5'd1);
        #1 chk("dst0_pc_write", pc_write_o, 1);
        tick();
        set_lw(5'd8);
        tick();
        set_id(1'b1, 5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0);
        #1 chk("addi_rt_pc_write", pc_write_o, 1);
        tick();
        // rt dependency that is really read does stall
        set_lw(5'd8);
        tick();
        set_add(5'd1, 5'd8);
        #1 chk("rt_lu_pc_write", pc_write_o, 0);
        tick();
        #1 chk("rt_lu_resume", pc_write_o, 1);
        // taken branch with no hazard flushes
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
        branch_taken_i = 1'b1;
        #1 chk("br_flush", if_id_flush_o, 1);
        chk("br_pc_write", pc_write_o, 1);
        tick();
        branch_taken_i = 1'b0;
        chk("pre_hold_stall_cnt", stall_cnt_o, 2);
        chk("pre_hold_bubble_cnt", bubble_cnt_o, 2);

        // Memory hold over a pending load-use
        set_lw(5'd8);
        tick();
        set_add(5'd8, 5'd1);
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_hold", pipe_hold_o, 1);
            chk("hold_pc_write", pc_write_o, 0);
            chk("hold_bubble", id_ex_bubble_o, 0);
            tick();
            chk("hold_state", state_o, 2);
        end
        mem_busy_i = 1'b0;
        #1 chk("post_hold_bubble", id_ex_bubble_o, 1);
        chk("post_hold_pc_write", pc_write_o, 0);
        chk("post_hold_hold", pipe_hold_o, 0);
        tick();
        chk("post_hold_state", state_o, 1);
        #1 chk("post_hold_resume", pc_write_o, 1);
        tick();
        chk("hold_stall_cnt", stall_cnt_o, 6);
        chk("hold_bubble_cnt", bubble_cnt_o, 3);

        // beq $8,$8 taken right after lw $8
        set_lw(5'd8);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        branch_taken_i = 1'b1;
        #1 chk("brlu_bubble", id_ex_bubble_o, 1);
        chk("brlu_flush", if_id_flush_o, 0);
        chk("brlu_pc_write", pc_write_o, 0);
        tick();
        #1 chk("brlu2_flush", if_id_flush_o, 1);
        chk("brlu2_pc_write", pc_write_o, 1);
        chk("brlu2_bubble", id_ex_bubble_o, 0);
        tick();
        branch_taken_i = 1'b0;
        chk("brlu_stall_cnt", stall_cnt_o, 7);
        chk("brlu_bubble_cnt", bubble_cnt_o, 4);

        // Reset during a load-use stall
        set_lw(5'd8);
        tick();
        set_add(5'd8, 5'd1);
        #1 chk("rstmid_lu", pc_write_o, 0);
        rst_i = 1'b0;
        #1 chk("rstmid_bubble", id_ex_bubble_o, 1);
        chk("rstmid_if_id_write", if_id_write_o, 0);
        tick();
        chk("rstmid_stall_cnt", stall_cnt_o, 0);
        chk("rstmid_bubble_cnt", bubble_cnt_o, 0);
        chk("rstmid_state", state_o, 0);
        rst_i = 1'b1;
        #1 chk("rstmid_release_pc", pc_write_o, 1);
        chk("rstmid_release_bubble", id_ex_bubble_o, 0);
        tick();

        // Counter wrap at CNT_W=4
        for (int i = 0; i < 16; i++) begin
            set_lw(5'd8);
            tick();
            set_add(5'd8, 5'd1);
            tick();
            tick();
            if (i == 14) begin
                chk("wrap_bubble_15", bubble_cnt_o, 15);
                chk("wrap_stall_15", stall_cnt_o, 15);
            end
        end
        chk("wrap_bubble_0", bubble_cnt_o, 0);
        chk("wrap_stall_0", stall_cnt_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
